// File: rtl/grid_pkg.sv
// grid_pkg: shared definitions for the grid cursor controller.
//   - Button index constants for btn_in bit positions.
//   - clog2w(): bit width needed to hold values 0..n-1, never less than 1.
//   - rpt_state_e: per-button auto-repeat FSM states.
package grid_pkg;

  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_UP    = 3;

  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rpt_state_e;

endpackage

// File: rtl/grid_cursor_ctrl_if.sv
// grid_cursor_ctrl_if: button input and cursor output bundle of the grid cursor controller.
//   btn_in    raw buttons [0]=right [1]=down [2]=left [3]=up
//   pos_x     cursor column
//   pos_y     cursor row
//   pos_index pos_y*COLS+pos_x
//   position  one-hot cell mask, bit pos_index set
//   move      one-cycle strobe when the cursor takes a new value
// Modports: master = the controller (drives the cursor), slave = board/consumer side.
interface grid_cursor_ctrl_if #(
  parameter int unsigned COLS = 4,
  parameter int unsigned ROWS = 4
);
  localparam int unsigned XW = grid_pkg::clog2w(COLS);
  localparam int unsigned YW = grid_pkg::clog2w(ROWS);
  localparam int unsigned IW = grid_pkg::clog2w(COLS * ROWS);
  localparam int unsigned N  = COLS * ROWS;

  logic [3:0]    btn_in;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [IW-1:0] pos_index;
  logic [N-1:0]  position;
  logic          move;

  modport master (
    input  btn_in,
    output pos_x,
    output pos_y,
    output pos_index,
    output position,
    output move
  );

  modport slave (
    output btn_in,
    input  pos_x,
    input  pos_y,
    input  pos_index,
    input  position,
    input  move
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce one raw button.
//   clk   system clock
//   rst   synchronous active-high reset
//   raw   asynchronous raw button level
//   level accepted (debounced) level
//   press one-cycle pulse on an accepted 0->1 transition
// A press is only reported once the button has been seen released since reset, so a
// button held through reset does not step the cursor until it is released and pressed again.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int unsigned CntW = grid_pkg::clog2w(DEBOUNCE_CYCLES);

  logic            meta_q, sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            armed_q, armed_d;
  logic [1:0]      fill_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    // fill_q[1] marks that sync_q holds a real sample rather than its reset value.
    armed_d = armed_q | (fill_q[1] & ~sync_q);
    press_d = level_d & ~level_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      armed_q <= armed_d;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: debounced 4-button cursor controller on a COLS x ROWS board.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  grid_cursor_ctrl_if.master: btn_in in; pos_x, pos_y, pos_index, position, move out
// Press events of one cycle combine into dx = R-L, dy = D-U; WRAP selects wrap vs saturate.
// Optional feature: define GRID_CURSOR_AUTO_REPEAT_EN to build hold-to-repeat, where a held
// button issues a synthetic press REPEAT_DELAY cycles after its press, then every
// REPEAT_PERIOD cycles until release.
module grid_cursor_ctrl
  import grid_pkg::*;
#(
  parameter int unsigned COLS            = 4,
  parameter int unsigned ROWS            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 800000,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input logic              clk,
  input logic              rst,
  grid_cursor_ctrl_if.master bus
);
  localparam int unsigned XW = clog2w(COLS);
  localparam int unsigned YW = clog2w(ROWS);
  localparam int unsigned IW = clog2w(COLS * ROWS);
  localparam int unsigned N  = COLS * ROWS;

  logic [3:0] level, press, evt;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.btn_in[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

`ifdef GRID_CURSOR_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = clog2w(RptMax);

  logic [3:0] rpt;

  for (genvar i = 0; i < 4; i++) begin : g_rpt
    rpt_state_e      st_q, st_d;
    logic [RptW-1:0] cnt_q, cnt_d;
    logic            pulse;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      pulse = 1'b0;
      unique case (st_q)
        StIdle: begin
          if (press[i]) begin
            st_d  = StDelay;
            cnt_d = '0;
          end
        end
        StDelay: begin
          if (!level[i]) begin
            st_d = StIdle;
          end else if (cnt_q == RptW'(REPEAT_DELAY - 1)) begin
            pulse = 1'b1;
            st_d  = StRepeat;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + RptW'(1);
          end
        end
        StRepeat: begin
          if (!level[i]) begin
            st_d = StIdle;
          end else if (cnt_q == RptW'(REPEAT_PERIOD - 1)) begin
            pulse = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + RptW'(1);
          end
        end
        default: st_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= StIdle;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign rpt[i] = pulse;
  end

  assign evt = press | rpt;
`else
  localparam int unsigned unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_level;
  assign unused_level = ^level;
  assign evt = press;
`endif

  logic          go_r, go_l, go_d, go_u;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [IW-1:0] index_q, index_d;
  logic [N-1:0]  position_q, position_d;
  logic          move_q, move_d;

  // Opposite presses in the same cycle cancel on that axis.
  assign go_r = evt[BTN_RIGHT] & ~evt[BTN_LEFT];
  assign go_l = evt[BTN_LEFT] & ~evt[BTN_RIGHT];
  assign go_d = evt[BTN_DOWN] & ~evt[BTN_UP];
  assign go_u = evt[BTN_UP] & ~evt[BTN_DOWN];

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (go_r) begin
      if (x_q == XW'(COLS - 1)) x_d = (WRAP != 0) ? '0 : x_q;
      else                      x_d = x_q + XW'(1);
    end else if (go_l) begin
      if (x_q == '0) x_d = (WRAP != 0) ? XW'(COLS - 1) : x_q;
      else           x_d = x_q - XW'(1);
    end
    if (go_d) begin
      if (y_q == YW'(ROWS - 1)) y_d = (WRAP != 0) ? '0 : y_q;
      else                      y_d = y_q + YW'(1);
    end else if (go_u) begin
      if (y_q == '0) y_d = (WRAP != 0) ? YW'(ROWS - 1) : y_q;
      else           y_d = y_q - YW'(1);
    end
    // A saturated axis leaves x_d/y_d unchanged, so move only reflects real changes.
    move_d     = (x_d != x_q) | (y_d != y_q);
    index_d    = IW'(y_d) * IW'(COLS) + IW'(x_d);
    position_d = N'(1) << index_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      index_q    <= '0;
      position_q <= N'(1);
      move_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      index_q    <= index_d;
      position_q <= position_d;
      move_q     <= move_d;
    end
  end

  assign bus.pos_x     = x_q;
  assign bus.pos_y     = y_q;
  assign bus.pos_index = index_q;
  assign bus.position  = position_q;
  assign bus.move      = move_q;
endmodule
